// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// Contents: FSM state encoding, opcode field position, two-word opcode constants,
// and the is_two_word() decode helper used by fetch_sequencer.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    OP    = 3'd2,
    IMM   = 3'd3,
    HOLD  = 3'd4
  } state_t;

  // Major opcode field inside a 16-bit instruction word
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  // Opcodes that are followed by an immediate word
  localparam logic [3:0] OPC_LDI = 4'h1;
  localparam logic [3:0] OPC_BOP = 4'h3;
  localparam logic [3:0] OPC_CAL = 4'h4;
  localparam logic [3:0] OPC_BEQ = 4'h5;
  localparam logic [3:0] OPC_BNE = 4'h6;

  function automatic logic is_two_word(input logic [3:0] opcode);
    case (opcode)
      OPC_LDI, OPC_BOP, OPC_CAL, OPC_BEQ, OPC_BNE: return 1'b1;
      default:                                     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_sequencer.sv
// Purpose: instruction-fetch initiator on program-memory read port 1; builds
//   {pc, opcode, imm} bundles and hands them to decode on instr_valid/instr_ready.
// Latency/backpressure: one-word bundle valid 2 cycles after FETCH, two-word 3;
//   the bundle is held stable in HOLD until instr_ready, no reads issued while held.
// Ports: clk, rst_n (async active-low), en; mem_addr/mem_read/mem_rdata (memory A1/Read1/R1,
//   data valid the cycle after mem_read); instr_* (decode bundle); redirect/redirect_pc (execute).
// Optional: define FETCH_PREFETCH_EN to prefetch the next opcode while holding a bundle.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] instr_pc,
  output logic [DATA_W-1:0] instr_word,
  output logic [DATA_W-1:0] instr_imm,
  output logic              instr_two_word,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] pc_seq;     // address of the next sequential opcode
  logic [DATA_W-1:0] op_data;    // opcode word seen in OP
  logic              op_two;
  logic              handshake;

`ifdef FETCH_PREFETCH_EN
  logic              hold_first; // first HOLD cycle: prefetch read goes out now
  logic              pf_valid;
  logic [DATA_W-1:0] pf_word;
  // A word prefetched earlier in HOLD replaces the live memory data in OP.
  assign op_data = pf_valid ? pf_word : mem_rdata;
`else
  assign op_data = mem_rdata;
`endif

  assign pc_plus1  = pc + ADDR_W'(1);
  assign pc_seq    = pc + (instr_two_word ? ADDR_W'(2) : ADDR_W'(1));
  assign op_two    = is_two_word(op_data[OPC_MSB:OPC_LSB]);
  assign handshake = instr_valid && instr_ready;

  always_comb begin
    mem_read = 1'b0;
    mem_addr = '0;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        mem_addr = pc;
      end
      OP: if (op_two) begin
        mem_read = 1'b1;
        mem_addr = pc_plus1;
      end
`ifdef FETCH_PREFETCH_EN
      HOLD: if (hold_first) begin
        mem_read = 1'b1;
        mem_addr = pc_seq;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pc             <= RESET_PC;
      instr_valid    <= 1'b0;
      instr_pc       <= '0;
      instr_word     <= '0;
      instr_imm      <= '0;
      instr_two_word <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      hold_first     <= 1'b0;
      pf_valid       <= 1'b0;
      pf_word        <= '0;
`endif
    end else if (redirect) begin
      // Redirect wins over everything; a bundle handshaking this cycle is
      // consumed but does not advance pc. Any read in flight is dropped.
      pc          <= redirect_pc;
      instr_valid <= 1'b0;
      if (state != IDLE) state <= FETCH;
`ifdef FETCH_PREFETCH_EN
      hold_first  <= 1'b0;
      pf_valid    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE:  if (en) state <= FETCH;
        FETCH: state <= OP;
        OP: begin
          instr_word     <= op_data;
          instr_pc       <= pc;
          instr_imm      <= '0;
          instr_two_word <= 1'b0;
`ifdef FETCH_PREFETCH_EN
          pf_valid       <= 1'b0;
`endif
          if (op_two) begin
            state <= IMM;
          end else begin
            state       <= HOLD;
            instr_valid <= 1'b1;
`ifdef FETCH_PREFETCH_EN
            hold_first  <= 1'b1;
`endif
          end
        end
        IMM: begin
          instr_imm      <= mem_rdata;
          instr_two_word <= 1'b1;
          instr_valid    <= 1'b1;
          state          <= HOLD;
`ifdef FETCH_PREFETCH_EN
          hold_first     <= 1'b1;
`endif
        end
        HOLD: begin
`ifdef FETCH_PREFETCH_EN
          hold_first <= 1'b0;
          // Second HOLD cycle: the prefetch result is on mem_rdata.
          if (!hold_first && !pf_valid) begin
            pf_word  <= mem_rdata;
            pf_valid <= 1'b1;
          end
`endif
          if (handshake) begin
            pc          <= pc_seq;
            instr_valid <= 1'b0;
            if (!en) begin
              state <= IDLE;
`ifdef FETCH_PREFETCH_EN
              pf_valid <= 1'b0;
`endif
            end else begin
`ifdef FETCH_PREFETCH_EN
              // Next opcode is either arriving next cycle or already in pf_word.
              state <= OP;
`else
              state <= FETCH;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
`timescale 1ns/1ps
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic [15:0] mem_rdata = 16'h0000;
  logic        instr_valid;
  logic [15:0] instr_pc, instr_word, instr_imm;
  logic        instr_two_word;

  logic [15:0] mem [0:1023];
  int errors = 0;
  int checks = 0;
  int accepted = 0;

  always #5 clk = ~clk;

  // 1k-word memory, registered read, aliased on the low address bits
  always @(posedge clk) if (mem_read) mem_rdata <= mem[mem_addr[9:0]];

  always @(posedge clk) if (rst_n && instr_valid && instr_ready) accepted <= accepted + 1;

  fetch_sequencer #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_pc(instr_pc),
    .instr_word(instr_word), .instr_imm(instr_imm), .instr_two_word(instr_two_word),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_bundle(input string name, input logic [15:0] pc, input logic [15:0] word,
                              input logic [15:0] imm, input logic two);
    check({name, " pc"},   32'(instr_pc), 32'(pc));
    check({name, " word"}, 32'(instr_word), 32'(word));
    check({name, " imm"},  32'(instr_imm), 32'(imm));
    check({name, " two"},  32'(instr_two_word), 32'(two));
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!instr_valid && n < 12) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (!instr_valid) begin
      errors++;
      $display("FAIL %s: no bundle within %0d cycles, instr_valid=%0b required 1", name, n, instr_valid);
    end
  endtask

  // Reference decode, written from the opcode list
  function automatic logic ref_two(input logic [15:0] w);
    logic [3:0] op;
    op = w[15:12];
    return op inside {4'h1, 4'h3, 4'h4, 4'h5, 4'h6};
  endfunction

  typedef struct {
    logic        en;
    logic        rdy;
    logic        rd;
    logic [15:0] addr;
    logic        vld;
    logic [15:0] pc;
    logic [15:0] word;
    logic [15:0] imm;
    logic        two;
  } vec_t;

  localparam int NROWS = 18;
  vec_t tbl [NROWS];

  initial begin
    logic [15:0] model_pc, exp_word, exp_imm, nxt;
    logic        exp_two, prev_redir, prev_stall;
    logic [15:0] sv_pc, sv_word, sv_imm;
    logic        sv_two;
    int          gap, acc0;

    //            en    rdy   rd    addr      vld   pc        word      imm       two
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}; // IDLE
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}; // FETCH 0
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}; // OP, imm read
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}; // IMM
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 16'h1010, 16'h0002, 1'b1}; // HOLD, take
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}; // FETCH 2
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}; // OP one-word
    for (int i = 7; i <= 11; i++)
      tbl[i] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h83ED, 16'h0000, 1'b0}; // stall
    tbl[12] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 16'h83ED, 16'h0000, 1'b0}; // take
    tbl[13] = '{1'b0, 1'b0, 1'b1, 16'h0003, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}; // FETCH 3, en low
    tbl[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}; // OP
    tbl[15] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0003, 16'h2000, 16'h0000, 1'b0}; // HOLD completes
    tbl[16] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}; // IDLE
    tbl[17] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0}; // IDLE

    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1010; mem[1] = 16'h0002; mem[2] = 16'h83ED; mem[3] = 16'h2000;
    mem[10'h00F] = 16'h2222; mem[10'h010] = 16'h1ABC; mem[10'h011] = 16'h5555;
    mem[10'h013] = 16'h7000; mem[10'h3FF] = 16'h4123;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    check("reset instr_valid", 32'(instr_valid), 32'h0);
    check("reset mem_read", 32'(mem_read), 32'h0);
    check("reset mem_addr", 32'(mem_addr), 32'h0);
    check_bundle("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: program 1010/0002/83ED/2000 with a stall and an en-low drain
    for (int i = 0; i < NROWS; i++) begin
      en = tbl[i].en;
      instr_ready = tbl[i].rdy;
      #1;
      check($sformatf("row%0d mem_read", i), 32'(mem_read), 32'(tbl[i].rd));
      check($sformatf("row%0d mem_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
      check($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) check_bundle($sformatf("row%0d", i), tbl[i].pc, tbl[i].word, tbl[i].imm, tbl[i].two);
      @(negedge clk);
    end

    // Redirect while IDLE moves pc but stays IDLE
    redirect = 1'b1; redirect_pc = 16'h0010; #1;
    @(negedge clk);
    redirect = 1'b0; en = 1'b1; #1;
    check("idle redirect no read", 32'(mem_read), 32'h0);
    @(negedge clk); #1;
    check("fetch after idle redirect", 32'(mem_addr), 32'h0010);
    @(negedge clk); #1;
    check("imm read addr", 32'(mem_addr), 32'h0011);
    @(negedge clk);
    // Redirect during IMM aborts the two-word instruction
    redirect = 1'b1; redirect_pc = 16'h000F; #1;
    check("imm state not valid", 32'(instr_valid), 32'h0);
    @(negedge clk);
    redirect = 1'b0; #1;
    check("abort valid", 32'(instr_valid), 32'h0);
    check("abort refetch addr", 32'(mem_addr), 32'h000F);
    wait_valid("after abort");
    check_bundle("after abort", 16'h000F, 16'h2222, 16'h0000, 1'b0);

    // Handshake and redirect together: consumed once, pc takes target
    acc0 = accepted;
    instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0013;
    @(negedge clk);
    instr_ready = 1'b0; redirect = 1'b0; #1;
    check("hs+redirect consumed once", 32'(accepted), 32'(acc0 + 1));
    check("hs+redirect valid drop", 32'(instr_valid), 32'h0);
    check("hs+redirect fetch addr", 32'(mem_addr), 32'h0013);
    wait_valid("at 0x13");
    check_bundle("at 0x13", 16'h0013, 16'h7000, 16'h0000, 1'b0);

    // Two-word opcode at 0xFFFF: immediate from 0x0000, next opcode at 0x0001
    redirect = 1'b1; redirect_pc = 16'hFFFF;
    @(negedge clk);
    redirect = 1'b0; #1;
    check("wrap fetch addr", 32'(mem_addr), 32'hFFFF);
    @(negedge clk); #1;
    check("wrap imm addr", 32'(mem_addr), 32'h0000);
    wait_valid("wrap");
    check_bundle("wrap", 16'hFFFF, 16'h4123, 16'h1010, 1'b1);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0; #1;
    check("wrap next fetch", 32'(mem_addr), 32'h0001);

    // Random program, random ready and redirects, checked as a bundle stream
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    model_pc = 16'h0001;
    prev_redir = 1'b0; prev_stall = 1'b0; gap = 0;
    sv_pc = '0; sv_word = '0; sv_imm = '0; sv_two = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect    = ($urandom_range(0, 19) == 0);
      redirect_pc = 16'($urandom);
      #1;
      if (prev_redir) check("rand valid after redirect", 32'(instr_valid), 32'h0);
      else if (prev_stall) begin
        check("rand stall valid", 32'(instr_valid), 32'h1);
        check_bundle("rand stall", sv_pc, sv_word, sv_imm, sv_two);
      end
      if (instr_valid && instr_ready) begin
        exp_word = mem[model_pc[9:0]];
        exp_two  = ref_two(exp_word);
        nxt      = model_pc + 16'd1;
        exp_imm  = exp_two ? mem[nxt[9:0]] : 16'h0000;
        check_bundle("rand", model_pc, exp_word, exp_imm, exp_two);
        model_pc = model_pc + (exp_two ? 16'd2 : 16'd1);
      end
      if (redirect) model_pc = redirect_pc;
      prev_stall = instr_valid && !instr_ready;
      sv_pc = instr_pc; sv_word = instr_word; sv_imm = instr_imm; sv_two = instr_two_word;
      prev_redir = redirect;
      if (instr_valid || redirect) gap = 0;
      else gap++;
      if (gap > 8) begin
        checks++; errors++;
        $display("FAIL rand progress: %0d cycles without a bundle, required at most 8", gap);
        break;
      end
    end

    // Reset mid-operation returns outputs to reset values at once
    redirect = 1'b0; instr_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset instr_valid", 32'(instr_valid), 32'h0);
    check("midreset mem_read", 32'(mem_read), 32'h0);
    check("midreset mem_addr", 32'(mem_addr), 32'h0);
    check_bundle("midreset", 16'h0000, 16'h0000, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
